// File: rtl/ysyx_040729_axi_mem_slave.sv
// AXI4 slave memory: one read or write burst at a time over a 64-bit word array with ID echo and address decode.
// Latency: first read beat RD_LATENCY cycles after the AR handshake; write beats accepted the cycle after the AW handshake.
// Backpressure: read beats and write response are held until r_ready/b_ready; AR/AW ready only in IDLE, W ready only in WR_DATA.
module ysyx_040729_axi_mem_slave #(
    parameter int                          AXI_DATA_WIDTH = 64,
    parameter int                          AXI_ADDR_WIDTH = 32,
    parameter int                          AXI_ID_WIDTH   = 4,
    parameter int                          MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0]   BASE_ADDR      = 32'h80000000,
    parameter int                          RD_LATENCY     = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          axi_aw_valid_i,
    output logic                          axi_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]       axi_aw_id_i,
    input  logic [7:0]                    axi_aw_len_i,
    input  logic [2:0]                    axi_aw_size_i,
    input  logic [1:0]                    axi_aw_burst_i,
    input  logic                          axi_w_valid_i,
    output logic                          axi_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_i,
    input  logic                          axi_w_last_i,
    output logic                          axi_b_valid_o,
    input  logic                          axi_b_ready_i,
    output logic [1:0]                    axi_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]       axi_b_id_o,
    input  logic                          axi_ar_valid_i,
    output logic                          axi_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]       axi_ar_id_i,
    input  logic [7:0]                    axi_ar_len_i,
    input  logic [2:0]                    axi_ar_size_i,
    input  logic [1:0]                    axi_ar_burst_i,
    output logic                          axi_r_valid_o,
    input  logic                          axi_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]     axi_r_data_o,
    output logic [1:0]                    axi_r_resp_o,
    output logic                          axi_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]       axi_r_id_o
);

    localparam int STRB_W  = AXI_DATA_WIDTH / 8;
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int OFF_LSB = $clog2(STRB_W);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * STRB_W);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_DATA, WR_RESP} state_t;

    state_t                       state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0]    addr_q;
    logic [7:0]                   len_q;
    logic [2:0]                   size_q;
    logic [1:0]                   burst_q;
    logic [AXI_ID_WIDTH-1:0]      id_q;
    logic [8:0]                   beat_q;
    logic [3:0]                   lat_cnt;
    logic                         dec_err_q;
    logic                         slv_err_q;
    logic                         last_was_write;
    logic                         last_was_read;

    logic [AXI_DATA_WIDTH-1:0]    mem [MEM_DEPTH];

    logic                         ar_win, aw_win;
    logic                         ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic [AXI_ADDR_WIDTH-1:0]    off, addr_nxt;
    logic [IDX_W-1:0]             idx;
    logic                         in_range;
    logic                         last_beat;

    // Start address aligned down to the transfer size.
    function automatic logic [AXI_ADDR_WIDTH-1:0] align(input logic [AXI_ADDR_WIDTH-1:0] a,
                                                        input logic [2:0] s);
        return a & ~((AXI_ADDR_WIDTH'(1) << s) - AXI_ADDR_WIDTH'(1));
    endfunction

    // A tie goes to the channel not served last; before any transfer the read wins.
    assign ar_win = (state == IDLE) && axi_ar_valid_i &&
                    (!axi_aw_valid_i || last_was_write || !last_was_read);
    assign aw_win = (state == IDLE) && axi_aw_valid_i && !ar_win;

    // Readies are gated by reset so they fall asynchronously even if a master holds valid.
    assign axi_ar_ready_o = reset & ar_win;
    assign axi_aw_ready_o = reset & aw_win;
    assign axi_w_ready_o  = (state == WR_DATA);

    assign ar_hs = axi_ar_valid_i & axi_ar_ready_o;
    assign aw_hs = axi_aw_valid_i & axi_aw_ready_o;
    assign w_hs  = axi_w_valid_i  & axi_w_ready_o;
    assign r_hs  = axi_r_valid_o  & axi_r_ready_i;
    assign b_hs  = axi_b_valid_o  & axi_b_ready_i;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the same bound check.
    assign off       = addr_q - BASE_ADDR;
    assign in_range  = (off < MEM_BYTES);
    assign idx       = off[OFF_LSB +: IDX_W];
    assign addr_nxt  = (burst_q == 2'b00) ? addr_q : addr_q + (AXI_ADDR_WIDTH'(1) << size_q);
    assign last_beat = (beat_q == {1'b0, len_q});

    assign axi_r_valid_o = (state == RD_BEAT);
    assign axi_r_data_o  = (axi_r_valid_o && in_range) ? mem[idx] : '0;
    assign axi_r_resp_o  = (axi_r_valid_o && !in_range) ? 2'b11 : 2'b00;
    assign axi_r_last_o  = axi_r_valid_o && last_beat;
    assign axi_r_id_o    = axi_r_valid_o ? id_q : '0;

    assign axi_b_valid_o = (state == WR_RESP);
    assign axi_b_resp_o  = !axi_b_valid_o ? 2'b00 :
                           dec_err_q      ? 2'b11 :
                           slv_err_q      ? 2'b10 : 2'b00;
    assign axi_b_id_o    = axi_b_valid_o ? id_q : '0;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = RD_WAIT;
                     else if (aw_hs) state_nxt = WR_DATA;
            RD_WAIT: if (lat_cnt == 4'd0) state_nxt = RD_BEAT;
            RD_BEAT: if (r_hs && last_beat) state_nxt = IDLE;
            WR_DATA: if (w_hs && axi_w_last_i) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst context: latched on the address handshake, advanced per data handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            id_q           <= '0;
            beat_q         <= '0;
            lat_cnt        <= '0;
            dec_err_q      <= 1'b0;
            slv_err_q      <= 1'b0;
            last_was_write <= 1'b0;
            last_was_read  <= 1'b0;
        end else if (ar_hs) begin
            addr_q         <= align(axi_ar_addr_i, axi_ar_size_i);
            len_q          <= axi_ar_len_i;
            size_q         <= axi_ar_size_i;
            burst_q        <= axi_ar_burst_i;
            id_q           <= axi_ar_id_i;
            beat_q         <= '0;
            lat_cnt        <= 4'(RD_LATENCY - 1);
            last_was_read  <= 1'b1;
            last_was_write <= 1'b0;
        end else if (aw_hs) begin
            addr_q         <= align(axi_aw_addr_i, axi_aw_size_i);
            len_q          <= axi_aw_len_i;
            size_q         <= axi_aw_size_i;
            burst_q        <= axi_aw_burst_i;
            id_q           <= axi_aw_id_i;
            beat_q         <= '0;
            dec_err_q      <= 1'b0;
            slv_err_q      <= (axi_aw_size_i > 3'd3);
            last_was_write <= 1'b1;
            last_was_read  <= 1'b0;
        end else if (state == RD_WAIT) begin
            if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
        end else if (r_hs) begin
            beat_q <= beat_q + 9'd1;
            addr_q <= addr_nxt;
        end else if (w_hs) begin
            beat_q <= beat_q + 9'd1;
            addr_q <= addr_nxt;
            if (!in_range) dec_err_q <= 1'b1;
            if (axi_w_last_i && !last_beat) slv_err_q <= 1'b1;
        end
    end

    // Byte-strobed write commit; beats past len or outside the window are dropped.
    always_ff @(posedge clock) begin
        if (w_hs && in_range && (beat_q <= {1'b0, len_q})) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_w_strb_i[i]) mem[idx][i*8 +: 8] <= axi_w_data_i[i*8 +: 8];
            end
        end
    end

endmodule

// File: doc/ysyx_040729_axi_mem_slave.md
# ysyx_040729_axi_mem_slave

AXI4 slave memory that sits directly downstream of the core's AXI master bridge and terminates the `axi_*` ports of the top level. It serves one read or write burst at a time from an internal 64-bit word array, with a programmable read latency, byte-strobed writes, ID echo and address decoding. It is the memory model for core bring-up and the timing reference for bridge verification.

## Interface
- AXI_DATA_WIDTH, 64, data bus width; fixed at 64.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_ID_WIDTH, 4, ID width.
- MEM_DEPTH, 1024, number of 64-bit words; power of two.
- BASE_ADDR, 32'h80000000, byte address of word 0.
- RD_LATENCY, 2, cycles from AR handshake to first `r_valid`; range 1..15.
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- axi_aw_valid_i / axi_aw_ready_o  in/out  1  write address handshake.
- axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i[7:0], axi_aw_size_i[2:0], axi_aw_burst_i[1:0]  in  write address fields.
- axi_w_valid_i / axi_w_ready_o  in/out  1  write data handshake.
- axi_w_data_i[63:0], axi_w_strb_i[7:0], axi_w_last_i  in  write data fields.
- axi_b_valid_o / axi_b_ready_i  out/in  1  write response handshake.
- axi_b_resp_o[1:0], axi_b_id_o  out  write response fields.
- axi_ar_valid_i / axi_ar_ready_o  in/out  1  read address handshake.
- axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i[7:0], axi_ar_size_i[2:0], axi_ar_burst_i[1:0]  in  read address fields.
- axi_r_valid_o / axi_r_ready_i  out/in  1  read data handshake.
- axi_r_data_o[63:0], axi_r_resp_o[1:0], axi_r_last_o, axi_r_id_o  out  read data fields.

## Operation
- FSM states:
  - IDLE: accepts a new read or write.
  - RD_WAIT: waits out RD_LATENCY.
  - RD_BEAT: returns read beats.
  - WR_DATA: accepts write beats.
  - WR_RESP: presents the write response.
- Arbitration in IDLE:
  - Only the winner's ready is driven high. `ar_ready` = winner-is-read, `aw_ready` = winner-is-write.
  - If only one of `ar_valid` / `aw_valid` is high, that channel wins.
  - If both are high, the channel not served last wins. A `last_was_write` flag is 0 after reset, so a read wins the first tie.
- Read:
  - On AR handshake, latch id, len, size, burst and address. Load the latency counter with RD_LATENCY-1 and go to RD_WAIT.
  - When the counter reaches 0, go to RD_BEAT with `r_valid` = 1.
  - Each r handshake advances the beat. `r_last` = 1 when beat == len. After the last handshake, go to IDLE.
- Write:
  - On AW handshake, latch the fields and go to WR_DATA with `w_ready` = 1.
  - Each w handshake writes the bytes of the current word whose `strb` bit is set, provided beat <= len and the address is in range.
  - The burst ends at the handshake carrying `w_last`; then go to WR_RESP.
- Beat address:
  - Start address is aligned down to 1<<size.
  - INCR (01) and WRAP (10) add 1<<size per beat. WRAP is treated as INCR.
  - FIXED (00) holds the address.
  - Word index = (addr - BASE_ADDR)>>3. Narrow reads return the full 64-bit word.
- Responses:
  - Read beat in range: OKAY (00). Out of range: DECERR (11), data 0.
  - Write: DECERR if any beat was out of range. Otherwise SLVERR (10) if `w_last` arrived at beat != len, or if size > 3. Otherwise OKAY.
  - `b_id` / `r_id` echo the latched id.
- Memory contents are not reset and are X/0 at start, depending on the simulator.

## Timing
- Reset values: every ready and valid = 0; data, resp, id = 0; `r_last` = 0; FSM = IDLE; `last_was_write` = 0.
- Reset assertion mid-burst drops all outputs immediately (asynchronously). The in-flight transaction is abandoned with no response. A write beat is committed only if its handshake happened before reset.
- A ready is asserted in the cycle the FSM enters IDLE. Both are deasserted in every other state.
- Read latency:
  - AR handshake at edge N gives first `r_valid` high after edge N+RD_LATENCY.
  - Back-to-back beats with `r_ready` held high give one beat per cycle.
  - `r_valid`, data, last and resp are held stable while `r_ready` = 0.
- Write: `w_ready` goes high the cycle after the AW handshake. With `w_valid` held high, one beat is accepted per cycle.
- `b_valid` is asserted the cycle after the `w_last` handshake and held until `b_ready`. The FSM returns to IDLE the cycle after the B handshake.
- Minimum turnaround between transactions is 1 idle cycle.

## Test plan
- Single read: preload word 0 = 64'h1122334455667788; AR addr 0x80000000, len 0, id 3 -> `r_valid` 2 cycles after handshake with that data, resp 00, last 1, id 3.
- INCR burst write then read: AW len 3 at 0x80000010 with data 1,2,3,4, strb 8'hFF -> b resp 00. AR at the same address, len 3 -> beats 1,2,3,4 with last only on beat 3; r_ready toggling every cycle keeps data stable.
- Strobe: word 5 holds 0; write 64'hFFFF_FFFF_FFFF_FFFF with strb 8'h0F -> readback 64'h00000000FFFFFFFF.
- Decode error: AR at 0x7FFFFFF8 -> resp 11, data 0. AW at BASE+MEM_DEPTH*8 -> b resp 11, memory unchanged.
- Arbitration: ar_valid and aw_valid rise together after reset -> read served first, write next. On the following tie, the read is served.
- Reset mid-burst: deassert reset during beat 2 of a len 7 read -> `r_valid` is 0 in the same cycle. After release, a new read is served normally.
